// File: rtl/vga_driver.sv
// 640x480@60 VGA timing generator: free-running line/frame counters decoded into
// sync, blanking, one-clock-early pixel requests and frame-boundary strobes.
module vga_driver #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_DISP  = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_DISP  = 480,
  parameter int V_FRONT = 10
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [15:0] pixel_data,
  output logic [9:0]  pixel_xpos,
  output logic [9:0]  pixel_ypos,
  output logic        data_req,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_en,
  output logic [15:0] vga_rgb,
  output logic        frame_start,
  output logic        frame_done
);

  localparam logic [9:0] H_TOTAL  = 10'(H_SYNC + H_BACK + H_DISP + H_FRONT);
  localparam logic [9:0] V_TOTAL  = 10'(V_SYNC + V_BACK + V_DISP + V_FRONT);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0] H_START  = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END    = 10'(H_SYNC + H_BACK + H_DISP);
  localparam logic [9:0] V_START  = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_END    = 10'(V_SYNC + V_BACK + V_DISP);
  // The request window leads the display window by one clock for the registered pixel stage.
  localparam logic [9:0] H_REQ_LO = H_START - 10'd1;
  localparam logic [9:0] H_REQ_HI = H_END - 10'd1;

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_last;
  logic       h_act;
  logic       h_req;
  logic       v_act;

  assign h_last = (h_cnt == H_TOTAL - 10'd1);

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (h_last) begin
      h_cnt <= 10'd0;
      v_cnt <= (v_cnt == V_TOTAL - 10'd1) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  always_comb begin
    h_act       = (h_cnt >= H_START) && (h_cnt < H_END);
    h_req       = (h_cnt >= H_REQ_LO) && (h_cnt < H_REQ_HI);
    v_act       = (v_cnt >= V_START) && (v_cnt < V_END);
    vga_hs      = (h_cnt >= H_SYNC_W);
    vga_vs      = (v_cnt >= V_SYNC_W);
    vga_en      = h_act && v_act;
    data_req    = h_req && v_act;
    pixel_xpos  = data_req ? (h_cnt - H_REQ_LO) : 10'd0;
    pixel_ypos  = data_req ? (v_cnt - V_START) : 10'd0;
    vga_rgb     = vga_en ? pixel_data : 16'h0000;
    frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    frame_done  = (h_cnt == H_END - 10'd1) && (v_cnt == V_END - 10'd1);
  end

endmodule

// File: tb/tb_vga_driver.sv
// Self-checking bench for vga_driver: real horizontal timing, shortened vertical timing so
// several frames fit in a short run; outputs compared each cycle against a time-based model.
module tb_vga_driver;

  localparam int HS = 96, HB = 48, HD = 640, HF = 16;
  localparam int VS = 2, VB = 3, VD = 6, VF = 2;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int HSTART = HS + HB;
  localparam int VSTART = VS + VB;
  localparam int FRAME = HT * VT;

  logic        vga_clk = 1'b0;
  logic        sys_rst;
  logic [15:0] pixel_data;
  logic [9:0]  pixel_xpos, pixel_ypos;
  logic        data_req, vga_hs, vga_vs, vga_en, frame_start, frame_done;
  logic [15:0] vga_rgb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = 0;
  bit chk_on = 1'b0;
  logic [15:0] pix_reg = 16'h0;
  logic [15:0] rnd_pix = 16'h0;

  vga_driver #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF)
  ) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .pixel_data(pixel_data),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .data_req(data_req),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_en(vga_en), .vga_rgb(vga_rgb),
    .frame_start(frame_start), .frame_done(frame_done)
  );

  always #5 vga_clk = ~vga_clk;

  // Pixel stage: registers an encoding of the requested coordinate.
  always @(posedge vga_clk) begin
    pix_reg <= {pixel_xpos[4:0], pixel_ypos[5:0], pixel_xpos[9:5]};
    rnd_pix <= 16'($urandom);
  end
  assign pixel_data = (mode == 1) ? 16'hFFFF : (mode == 2) ? rnd_pix : pix_reg;

  // Clock edges since reset release: the frame position follows from plain division.
  always @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [41:0] model_out(input int c, input logic [15:0] pd, input int m);
    int h, v, x, y;
    logic hs, vs, en, req, fs, fd;
    logic [9:0] dx, dy;
    logic [15:0] rgb;
    h   = c % HT;
    v   = (c / HT) % VT;
    hs  = (h >= HS);
    vs  = (v >= VS);
    en  = (h >= HSTART) && (h < HSTART + HD) && (v >= VSTART) && (v < VSTART + VD);
    req = (h >= HSTART - 1) && (h < HSTART + HD - 1) && (v >= VSTART) && (v < VSTART + VD);
    x   = req ? h - (HSTART - 1) : 0;
    y   = req ? v - VSTART : 0;
    fs  = (h == 0) && (v == 0);
    fd  = (h == HSTART + HD - 1) && (v == VSTART + VD - 1);
    dx  = 10'(h - HSTART);
    dy  = 10'(v - VSTART);
    if (!en)         rgb = 16'h0000;
    else if (m == 0) rgb = {dx[4:0], dy[5:0], dx[9:5]};
    else if (m == 1) rgb = 16'hFFFF;
    else             rgb = pd;
    return {hs, vs, en, req, fs, fd, 10'(x), 10'(y), rgb};
  endfunction

  always @(negedge vga_clk) begin
    if (chk_on)
      chk_val("cycle_outputs",
              64'({vga_hs, vga_vs, vga_en, data_req, frame_start, frame_done,
                   pixel_xpos, pixel_ypos, vga_rgb}),
              64'(model_out(cyc, pixel_data, mode)));
  end

  // Edge/interval monitors for sync widths, request window edges, per-frame counts and strobes.
  int gclk = 0;
  logic prev_hs = 1'b0, prev_vs = 1'b0, prev_req = 1'b0;
  logic [9:0] prev_x = 10'd0;
  int hs_fall_t, hs_rise_t, vs_fall_t, vs_rise_t, fd_t, fs_t;
  bit hs_fall_ok = 0, hs_rise_ok = 0, vs_fall_ok = 0, vs_rise_ok = 0;
  bit fd_ok = 0, fs_ok = 0;
  int req_cnt = 0, en_cnt = 0, row_exp = 0;

  always @(negedge vga_clk) begin
    gclk     <= gclk + 1;
    prev_hs  <= vga_hs;
    prev_vs  <= vga_vs;
    prev_req <= data_req;
    prev_x   <= pixel_xpos;
    if (sys_rst || !chk_on) begin
      hs_fall_ok <= 0; hs_rise_ok <= 0; vs_fall_ok <= 0; vs_rise_ok <= 0;
      fd_ok <= 0; fs_ok <= 0; row_exp <= 0;
    end else begin
      if (prev_hs && !vga_hs) begin
        if (hs_fall_ok) chk_val("hs_period", 64'(gclk - hs_fall_t), 64'(HT));
        if (hs_rise_ok) chk_val("hs_high", 64'(gclk - hs_rise_t), 64'(HT - HS));
        hs_fall_t <= gclk; hs_fall_ok <= 1;
      end
      if (!prev_hs && vga_hs) begin
        if (hs_fall_ok) chk_val("hs_low", 64'(gclk - hs_fall_t), 64'(HS));
        hs_rise_t <= gclk; hs_rise_ok <= 1;
      end
      if (prev_vs && !vga_vs) begin
        if (vs_fall_ok) chk_val("vs_period", 64'(gclk - vs_fall_t), 64'(FRAME));
        vs_fall_t <= gclk; vs_fall_ok <= 1;
      end
      if (!prev_vs && vga_vs) begin
        if (vs_fall_ok) chk_val("vs_low", 64'(gclk - vs_fall_t), 64'(VS * HT));
        vs_rise_t <= gclk; vs_rise_ok <= 1;
      end
      if (!prev_req && data_req) begin
        chk_val("req_rise_h", 64'(cyc % HT), 64'(HSTART - 1));
        chk_val("req_rise_x", 64'(pixel_xpos), 64'd0);
        chk_val("req_row", 64'(pixel_ypos), 64'(row_exp));
        row_exp <= (row_exp + 1) % VD;
      end
      if (prev_req && !data_req) begin
        chk_val("req_last_x", 64'(prev_x), 64'(HD - 1));
        chk_val("req_last_h", 64'((cyc - 1) % HT), 64'(HSTART + HD - 2));
      end
      if (frame_done) begin
        fd_t <= gclk; fd_ok <= 1;
      end
      if (frame_start) begin
        if (fd_ok) chk_val("fd_to_fs", 64'(gclk - fd_t), 64'(HT - (HSTART + HD - 1) + VF * HT));
        if (fs_ok) begin
          chk_val("fs_period", 64'(gclk - fs_t), 64'(FRAME));
          chk_val("req_per_frame", 64'(req_cnt), 64'(HD * VD));
          chk_val("en_per_frame", 64'(en_cnt), 64'(HD * VD));
        end
        fs_t <= gclk; fs_ok <= 1;
      end
    end
    if (sys_rst || frame_start) begin
      req_cnt <= 0; en_cnt <= 0;
    end else begin
      req_cnt <= req_cnt + int'(data_req);
      en_cnt  <= en_cnt + int'(vga_en);
    end
  end

  task automatic wait_fs(input string tag);
    int n;
    for (n = 0; n < FRAME + 10; n++) begin
      @(negedge vga_clk);
      if (frame_start) break;
    end
    chk_val(tag, 64'(n < FRAME + 10), 64'd1);
  endtask

  initial begin
    int n, rh, rv, hold;
    sys_rst = 1'b1;
    @(posedge vga_clk);
    chk_on = 1'b1;
    repeat (4) @(posedge vga_clk);
    @(negedge vga_clk);
    chk_val("rst_hs", 64'(vga_hs), 64'd0);
    chk_val("rst_vs", 64'(vga_vs), 64'd0);
    chk_val("rst_rgb", 64'(vga_rgb), 64'd0);
    chk_val("rst_fs", 64'(frame_start), 64'd1);
    $display("reset phase done, releasing");
    sys_rst = 1'b0;
    for (n = 1; n < 2000; n++) begin
      @(negedge vga_clk);
      if (vga_hs) break;
    end
    chk_val("hs_rise_edges", 64'(n), 64'(HS));

    wait_fs("frame1_timeout");
    $display("frame 1 complete (encoded pixels)");
    wait_fs("frame2_timeout");
    $display("frame 2 complete (encoded pixels)");
    @(posedge vga_clk); #1 mode = 1;
    wait_fs("frame3_timeout");
    $display("frame 3 complete (constant white)");
    @(posedge vga_clk); #1 mode = 2;

    rh = HSTART + $urandom_range(0, HD - 1);
    rv = VSTART + $urandom_range(0, VD - 1);
    for (n = 0; n < FRAME + 10; n++) begin
      @(negedge vga_clk);
      if ((cyc % HT) == rh && ((cyc / HT) % VT) == rv) break;
    end
    chk_val("mid_point_found", 64'(n < FRAME + 10), 64'd1);
    chk_val("mid_en_before", 64'(vga_en), 64'd1);
    #2 sys_rst = 1'b1;
    #1;
    chk_val("async_en_drop", 64'(vga_en), 64'd0);
    chk_val("async_fs", 64'(frame_start), 64'd1);
    chk_val("async_hs", 64'(vga_hs), 64'd0);
    $display("async reset at h=%0d v=%0d", rh, rv);
    hold = $urandom_range(1, 4);
    repeat (hold) @(posedge vga_clk);
    @(negedge vga_clk);
    sys_rst = 1'b0;
    for (n = 1; n < FRAME + 10; n++) begin
      @(negedge vga_clk);
      if (frame_done) break;
    end
    chk_val("fd_after_release", 64'(n), 64'((VSTART + VD - 1) * HT + HSTART + HD - 1));
    wait_fs("frame_after_rst_timeout");
    repeat (HT) @(negedge vga_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
